// File: rtl/select_multi_if.sv
// select_multi_if: bundle between the reservation station / issue ports and
// the multi-issue select stage.
//   reqs        : per-entry ready-to-issue vector (RS -> select)
//   flush       : kill all held grants (RS -> select)
//   issue_ready : per-port accept strobe (issue ports -> select)
//   grant       : registered entry index per port (select -> issue ports)
//   grant_valid : registered per-port live-grant flag (select -> issue ports)
//   accept_mask : combinational entries firing this cycle (select -> RS)
// master = RS/issue side, slave = select stage.
interface select_multi_if #(
  parameter int RS_ENTRIES  = 16,
  parameter int ISSUE_WIDTH = 2
);
  localparam int IDX_W = $clog2(RS_ENTRIES);

  logic [RS_ENTRIES-1:0]             reqs;
  logic                              flush;
  logic [ISSUE_WIDTH-1:0]            issue_ready;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0] grant;
  logic [ISSUE_WIDTH-1:0]            grant_valid;
  logic [RS_ENTRIES-1:0]             accept_mask;

  modport master (
    output reqs, flush, issue_ready,
    input  grant, grant_valid, accept_mask
  );

  modport slave (
    input  reqs, flush, issue_ready,
    output grant, grant_valid, accept_mask
  );
endinterface

// File: rtl/select_multi.sv
// select_multi: multi-issue select stage. Each cycle fills every free issue
// port (ascending port order) with a distinct ready entry, scanning entries
// in rotating priority from ptr. Grants are held per port until the port
// accepts them, so one stalled port never blocks the others.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : select_multi_if.slave (reqs, flush, issue_ready in;
//         grant, grant_valid, accept_mask out)

// Per-port grant register. load wins over drop so a port that fires can be
// refilled in the same edge (back-to-back issue).
module select_multi_lane #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic             drop,
  output logic [IDX_W-1:0] grant,
  output logic             grant_valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
    end else if (load) begin
      grant       <= load_idx;
      grant_valid <= 1'b1;
    end else if (drop) begin
      grant_valid <= 1'b0;
    end
  end
endmodule

module select_multi #(
  parameter int RS_ENTRIES  = 16,
  parameter int ISSUE_WIDTH = 2
) (
  input logic         clk,
  input logic         rst,
  select_multi_if.slave bus
);
  localparam int IDX_W = $clog2(RS_ENTRIES);

  logic [ISSUE_WIDTH-1:0][IDX_W-1:0] grant_q;
  logic [ISSUE_WIDTH-1:0]            gv;
  logic [ISSUE_WIDTH-1:0]            fire, kill, drop, load, avail;
  logic [ISSUE_WIDTH-1:0][IDX_W-1:0] load_idx;
  logic [RS_ENTRIES-1:0]             held, cand, accept;
  logic [IDX_W-1:0]                  ptr, ptr_nxt, idx;
  logic                              hit;

  // flush suppresses firing so nothing is deallocated in the flush cycle
  assign fire = gv & bus.issue_ready & {ISSUE_WIDTH{~bus.flush}};
  assign drop = fire | kill | {ISSUE_WIDTH{bus.flush}};

  // Held set includes firing ports: an entry leaving this cycle still has
  // reqs high, and must not be granted again.
  always_comb begin
    held   = '0;
    accept = '0;
    kill   = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      if (gv[p])   held[grant_q[p]]   = 1'b1;
      if (fire[p]) accept[grant_q[p]] = 1'b1;
      // stalled grant whose request vanished: retire it, no refill this cycle
      kill[p] = gv[p] & ~fire[p] & ~bus.reqs[grant_q[p]];
    end
  end

  assign cand = bus.reqs & ~held;

  // Walk entries in rotating order; each candidate goes to the lowest free
  // port still unfilled. ptr advances past the last entry actually loaded.
  always_comb begin
    avail    = (~gv | fire) & {ISSUE_WIDTH{~bus.flush}};
    load     = '0;
    load_idx = '0;
    ptr_nxt  = ptr;
    idx      = '0;
    hit      = 1'b0;
    for (int k = 0; k < RS_ENTRIES; k++) begin
      idx = ptr + IDX_W'(k);
      hit = 1'b0;
      if (cand[idx]) begin
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
          if (avail[p] && !hit) begin
            hit         = 1'b1;
            avail[p]    = 1'b0;
            load[p]     = 1'b1;
            load_idx[p] = idx;
          end
        end
        if (hit) ptr_nxt = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

  for (genvar p = 0; p < ISSUE_WIDTH; p++) begin : g_lane
    select_multi_lane #(.IDX_W(IDX_W)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .load        (load[p]),
      .load_idx    (load_idx[p]),
      .drop        (drop[p]),
      .grant       (grant_q[p]),
      .grant_valid (gv[p])
    );
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv;
  assign bus.accept_mask = accept;
endmodule
